// File: rtl/vga_scan.sv
// 640x480 VGA scan generator: pixel counters, sprite address outputs and a 2-stage
// colour/sync pipeline aligned with the 1-clk sprite lookup. Option macro: VGA_GROUND_EN.
module vga_scan #(
    parameter logic [11:0] BG_COLOR = 12'hFFF,
    parameter logic [11:0] FG_COLOR = 12'h555
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       px,
    output logic [8:0] row_addr,
    output logic [9:0] col_addr,
    output logic       fresh,
    output logic       hs,
    output logic       vs,
    output logic       rdn,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);
    localparam logic [9:0] H_VIS      = 10'd640;
    localparam logic [9:0] H_SYNC_BEG = 10'd656;
    localparam logic [9:0] H_SYNC_END = 10'd752;
    localparam logic [9:0] H_LAST     = 10'd799;
    localparam logic [9:0] V_VIS      = 10'd480;
    localparam logic [9:0] V_SYNC_BEG = 10'd490;
    localparam logic [9:0] V_SYNC_END = 10'd492;
    localparam logic [9:0] V_LAST     = 10'd524;

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic [9:0] w_hcnt_nxt;
    logic [9:0] w_vcnt_nxt;
    logic       w_vis_nxt;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_von;
    logic       w_fg;
    logic       r_hs1;
    logic       r_vs1;
    logic       r_von1;

    always_comb begin
        w_hcnt_nxt = (r_hcnt == H_LAST) ? 10'd0 : r_hcnt + 10'd1;
        w_vcnt_nxt = r_vcnt;
        if (r_hcnt == H_LAST) begin
            w_vcnt_nxt = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end
        w_vis_nxt = (w_hcnt_nxt < H_VIS) && (w_vcnt_nxt < V_VIS);
        w_hs_raw  = !((r_hcnt >= H_SYNC_BEG) && (r_hcnt < H_SYNC_END));
        w_vs_raw  = !((r_vcnt >= V_SYNC_BEG) && (r_vcnt < V_SYNC_END));
        w_von     = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    end

    // NOTE: addresses are built from the next count so they change together with hcnt/vcnt.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            r_hcnt   <= 10'd0;
            r_vcnt   <= 10'd0;
            row_addr <= 9'd0;
            col_addr <= 10'd0;
            fresh    <= 1'b0;
        end else begin
            r_hcnt   <= w_hcnt_nxt;
            r_vcnt   <= w_vcnt_nxt;
            row_addr <= w_vis_nxt ? w_vcnt_nxt[8:0] : 9'h1FF;
            col_addr <= w_vis_nxt ? w_hcnt_nxt : 10'h3FF;
            fresh    <= (w_vcnt_nxt < V_VIS);
        end
    end

    // Stage 1: hold sync/video-on for the cycle the sprite needs to answer.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_von1 <= 1'b0;
        end else begin
            r_hs1  <= w_hs_raw;
            r_vs1  <= w_vs_raw;
            r_von1 <= w_von;
        end
    end

`ifdef VGA_GROUND_EN
    logic r_gnd1;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            r_gnd1 <= 1'b0;
        end else begin
            r_gnd1 <= w_von && ((r_vcnt == 10'd402) || (r_vcnt == 10'd403));
        end
    end

    assign w_fg = px | r_gnd1;
`else
    assign w_fg = px;
`endif

    // Stage 2: colour and syncs leave together so the monitor sees them aligned.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            hs        <= 1'b1;
            vs        <= 1'b1;
            rdn       <= 1'b1;
            {r, g, b} <= 12'h000;
        end else begin
            hs        <= r_hs1;
            vs        <= r_vs1;
            rdn       <= ~r_von1;
            {r, g, b} <= r_von1 ? (w_fg ? FG_COLOR : BG_COLOR) : 12'h000;
        end
    end
endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: reset, line/frame timing, blanking, sprite alignment and
// the optional ground line; counters are jumped ahead to reach far rows quickly.
module tb_vga_scan;
    localparam logic [11:0] FG = 12'h555;
    localparam logic [11:0] BG = 12'hFFF;
`ifdef VGA_GROUND_EN
    localparam bit GROUND = 1'b1;
`else
    localparam bit GROUND = 1'b0;
`endif

    logic       clk;
    logic       RESET_N;
    logic       px;
    logic [8:0] row_addr;
    logic [9:0] col_addr;
    logic       fresh, hs, vs, rdn;
    logic [3:0] r, g, b;
    logic [1:0] px_mode;
    int         total;
    int         bad;

    vga_scan #(.BG_COLOR(BG), .FG_COLOR(FG)) dut (
        .clk(clk), .RESET_N(RESET_N), .px(px),
        .row_addr(row_addr), .col_addr(col_addr), .fresh(fresh),
        .hs(hs), .vs(vs), .rdn(rdn), .r(r), .g(g), .b(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite stand-in: answers one clock after the address (mode 0: off, 1: always on, 2: one pixel).
    always @(posedge clk) begin
        px <= (px_mode == 2'd1) || (px_mode == 2'd2 && col_addr == 10'd100 && row_addr == 9'd200);
    end

    function automatic void pos_at(input int h0, input int v0, input int k, output int h, output int v);
        int c;
        c = h0 + k;
        h = c % 800;
        v = (v0 + c / 800) % 525;
    endfunction

    function automatic logic [11:0] exp_color(input int h, input int v, input logic pxv);
        if (h >= 640 || v >= 480) return 12'h000;
        if (pxv || (GROUND && (v == 402 || v == 403))) return FG;
        return BG;
    endfunction

    // Called at a falling edge: the next rising edge continues from (h, v).
    task automatic jump(input int h, input int v);
        dut.r_hcnt = 10'(h);
        dut.r_vcnt = 10'(v);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (row_addr !== 9'd0) begin bad++; $display("FAIL rst_row got=%h want=0", row_addr); end
        total++; if (col_addr !== 10'd0) begin bad++; $display("FAIL rst_col got=%h want=0", col_addr); end
        total++; if (fresh !== 1'b0) begin bad++; $display("FAIL rst_fresh got=%b want=0", fresh); end
        total++; if ({hs, vs, rdn} !== 3'b111) begin bad++; $display("FAIL rst_sync got=%b want=111", {hs, vs, rdn}); end
        total++; if ({r, g, b} !== 12'h000) begin bad++; $display("FAIL rst_rgb got=%h want=000", {r, g, b}); end
        RESET_N = 1'b1;
        @(negedge clk);
        total++; if (col_addr !== 10'd1) begin bad++; $display("FAIL rel_col got=%0d want=1", col_addr); end
        total++; if (row_addr !== 9'd0) begin bad++; $display("FAIL rel_row got=%0d want=0", row_addr); end
        total++; if (fresh !== 1'b1) begin bad++; $display("FAIL rel_fresh got=%b want=1", fresh); end
        @(negedge clk);
        total++; if (rdn !== 1'b0) begin bad++; $display("FAIL rel_rdn got=%b want=0", rdn); end
        total++; if ({r, g, b} !== BG) begin bad++; $display("FAIL rel_rgb got=%h want=%h", {r, g, b}, BG); end
    endtask

    task automatic test_hsync();
        int h, v, fall1, rise1, fall2;
        logic prev_hs, exp_hs;
        fall1 = -1; rise1 = -1; fall2 = -1; prev_hs = 1'b1;
        px_mode = 2'd0;
        jump(640, 10);
        for (int j = 1; j <= 830; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                pos_at(640, 10, j - 2, h, v);
                exp_hs = !(h >= 656 && h < 752);
                total++; if (hs !== exp_hs) begin bad++; $display("FAIL hs_level h=%0d got=%b want=%b", h, hs, exp_hs); end
                total++; if (rdn !== (h >= 640)) begin bad++; $display("FAIL hs_rdn h=%0d got=%b want=%b", h, rdn, h >= 640); end
                total++; if ({r, g, b} !== exp_color(h, v, 1'b0)) begin bad++; $display("FAIL hs_rgb h=%0d got=%h want=%h", h, {r, g, b}, exp_color(h, v, 1'b0)); end
                if (prev_hs && !hs) begin
                    if (fall1 < 0) fall1 = j; else if (fall2 < 0) fall2 = j;
                end
                if (!prev_hs && hs && rise1 < 0) rise1 = j;
            end
            prev_hs = hs;
        end
        total++; if (fall1 !== 18) begin bad++; $display("FAIL hs_fall_lat got=%0d want=18", fall1); end
        total++; if (rise1 - fall1 !== 96) begin bad++; $display("FAIL hs_width got=%0d want=96", rise1 - fall1); end
        total++; if (fall2 - fall1 !== 800) begin bad++; $display("FAIL line_period got=%0d want=800", fall2 - fall1); end
    endtask

    task automatic test_blanking();
        int h, v;
        logic vis;
        px_mode = 2'd1;
        jump(620, 479);
        for (int j = 1; j <= 900; j++) begin
            @(negedge clk);
            pos_at(620, 479, j, h, v);
            vis = (h < 640) && (v < 480);
            total++; if (col_addr !== (vis ? 10'(h) : 10'h3FF)) begin bad++; $display("FAIL blk_col h=%0d v=%0d got=%h", h, v, col_addr); end
            total++; if (row_addr !== (vis ? 9'(v) : 9'h1FF)) begin bad++; $display("FAIL blk_row h=%0d v=%0d got=%h", h, v, row_addr); end
            total++; if (fresh !== (v < 480)) begin bad++; $display("FAIL blk_fresh v=%0d got=%b", v, fresh); end
            if (j >= 3) begin
                pos_at(620, 479, j - 2, h, v);
                vis = (h < 640) && (v < 480);
                total++; if (rdn !== !vis) begin bad++; $display("FAIL blk_rdn h=%0d v=%0d got=%b want=%b", h, v, rdn, !vis); end
                total++; if ({r, g, b} !== exp_color(h, v, 1'b1)) begin bad++; $display("FAIL blk_rgb h=%0d v=%0d got=%h want=%h", h, v, {r, g, b}, exp_color(h, v, 1'b1)); end
            end
        end
    endtask

    task automatic test_sprite();
        int h, v, hits;
        logic [11:0] want;
        px_mode = 2'd2;
        for (int row = 199; row <= 200; row++) begin
            hits = 0;
            jump(95, row);
            for (int j = 1; j <= 20; j++) begin
                @(negedge clk);
                if (j >= 3) begin
                    pos_at(95, row, j - 2, h, v);
                    want = (h == 100 && v == 200) ? FG : BG;
                    if ({r, g, b} === FG) hits++;
                    total++; if ({r, g, b} !== want) begin bad++; $display("FAIL spr_rgb h=%0d v=%0d got=%h want=%h", h, v, {r, g, b}, want); end
                end
            end
            total++; if (hits !== (row == 200 ? 1 : 0)) begin bad++; $display("FAIL spr_hits row=%0d got=%0d", row, hits); end
        end
    endtask

    task automatic test_vframe();
        int starts[4] = '{479, 489, 491, 524};
        int h, v, falls;
        logic vis, prev_fresh;
        px_mode = 2'd0;
        foreach (starts[s]) begin
            falls = 0;
            prev_fresh = 1'b1;
            jump(795, starts[s]);
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                pos_at(795, starts[s], j, h, v);
                vis = (h < 640) && (v < 480);
                total++; if (fresh !== (v < 480)) begin bad++; $display("FAIL vf_fresh h=%0d v=%0d got=%b", h, v, fresh); end
                total++; if (col_addr !== (vis ? 10'(h) : 10'h3FF)) begin bad++; $display("FAIL vf_col h=%0d v=%0d got=%h", h, v, col_addr); end
                total++; if (row_addr !== (vis ? 9'(v) : 9'h1FF)) begin bad++; $display("FAIL vf_row h=%0d v=%0d got=%h", h, v, row_addr); end
                if (j >= 2 && prev_fresh && !fresh) falls++;
                prev_fresh = fresh;
                if (j >= 3) begin
                    pos_at(795, starts[s], j - 2, h, v);
                    total++; if (vs !== !(v == 490 || v == 491)) begin bad++; $display("FAIL vf_vs h=%0d v=%0d got=%b", h, v, vs); end
                end
            end
            if (s == 0) begin
                total++; if (falls !== 1) begin bad++; $display("FAIL vf_fresh_falls got=%0d want=1", falls); end
            end
        end
    endtask

    task automatic test_ground();
        int h, v;
        px_mode = 2'd0;
        jump(798, 401);
        for (int j = 1; j <= 1610; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                pos_at(798, 401, j - 2, h, v);
                total++; if ({r, g, b} !== exp_color(h, v, 1'b0)) begin bad++; $display("FAIL gnd_rgb h=%0d v=%0d got=%h want=%h", h, v, {r, g, b}, exp_color(h, v, 1'b0)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        px_mode = 2'd0;
        jump(299, 200);
        @(negedge clk);
        total++; if (col_addr !== 10'd300 || row_addr !== 9'd200) begin bad++; $display("FAIL mid_pos got=%0d,%0d want=300,200", col_addr, row_addr); end
        RESET_N = 1'b0;
        @(negedge clk);
        total++; if (col_addr !== 10'd0 || row_addr !== 9'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d,%0d want=0,0", col_addr, row_addr); end
        total++; if ({hs, vs, rdn, fresh} !== 4'b1110) begin bad++; $display("FAIL mid_rst_ctl got=%b want=1110", {hs, vs, rdn, fresh}); end
        total++; if ({r, g, b} !== 12'h000) begin bad++; $display("FAIL mid_rst_rgb got=%h want=000", {r, g, b}); end
        RESET_N = 1'b1;
        @(negedge clk);
        total++; if (col_addr !== 10'd1 || row_addr !== 9'd0 || fresh !== 1'b1) begin bad++; $display("FAIL mid_resume got=%0d,%0d,%b want=1,0,1", col_addr, row_addr, fresh); end
        for (int j = 2; j <= 4; j++) begin
            @(negedge clk);
            total++; if ({hs, vs, rdn} !== 3'b110 || {r, g, b} !== BG) begin bad++; $display("FAIL mid_video j=%0d got=%b/%h want=110/%h", j, {hs, vs, rdn}, {r, g, b}, BG); end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        px_mode = 2'd0;
        RESET_N = 1'b0;
        test_reset();
        test_hsync();
        test_blanking();
        test_sprite();
        test_vframe();
        test_ground();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
